// File: rtl/dfe_multitap_pam_if.sv
// Sample, coefficient-load and result bus of the multi-tap PAM decision feedback equalizer.
// Handshake: a sample is taken on a rising edge only when signal_in_valid=1, load_mem=0 and done_wait=1;
// signal_out_valid is a one-cycle strobe with no back-pressure, and signal_out/est_out hold until the next one.
interface dfe_multitap_pam_if #(parameter int SIGNAL_RESOLUTION = 8);
  logic signed [SIGNAL_RESOLUTION-1:0] signal_in;
  logic                                signal_in_valid;
  logic                                dfe_en;
  logic                                load_mem;
  logic [7:0]                          location;
  logic [31:0]                         mem_data;
  logic                                done_wait;
  logic                                loc_err;
  logic signed [SIGNAL_RESOLUTION-1:0] signal_out;
  logic                                signal_out_valid;
  logic signed [SIGNAL_RESOLUTION-1:0] est_out;
  logic [15:0]                         drop_cnt;

  modport master (
    output signal_in, signal_in_valid, dfe_en, load_mem, location, mem_data,
    input  done_wait, loc_err, signal_out, signal_out_valid, est_out, drop_cnt
  );

  modport slave (
    input  signal_in, signal_in_valid, dfe_en, load_mem, location, mem_data,
    output done_wait, loc_err, signal_out, signal_out_valid, est_out, drop_cnt
  );
endinterface

// File: rtl/dfe_multitap_pam.sv
// Multi-tap decision feedback equalizer with a PAM2/PAM4 slicer and a loadable coefficient memory.
// Location 0 holds the main-cursor shift s0, locations 1..NUM_TAPS the post-cursor tap mantissas.
module dfe_multitap_pam #(
  parameter int NUM_TAPS          = 4,
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int PAM_LEVELS        = 4
) (
  input logic               clk,
  input logic               rst,
  dfe_multitap_pam_if.slave bus
);
  localparam int W  = SIGNAL_RESOLUTION;
  localparam int AW = W + 16 + $clog2(NUM_TAPS) + 17;
  localparam int S  = SYMBOL_SEPERATION;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [W-1:0]  LV_P3   = W'(3 * S / 2);
  localparam logic signed [W-1:0]  LV_P1   = W'(S / 2);
  localparam logic signed [W-1:0]  LV_M1   = W'(-(S / 2));
  localparam logic signed [W-1:0]  LV_M3   = W'(-(3 * S / 2));

  logic        [3:0]    r_s0;
  logic signed [15:0]   r_coef [1:NUM_TAPS];
  logic signed [W-1:0]  r_hist [1:NUM_TAPS];
  logic [NUM_TAPS:0]    r_loaded;
  logic                 r_done;
  logic                 r_loc_err;
  logic                 r_valid;
  logic signed [W-1:0]  r_out;
  logic signed [W-1:0]  r_est;
  logic [15:0]          r_drop;

  logic                 w_loc_ok;
  logic                 w_wr;
  logic                 w_accept;
  logic [3:0]           w_s0_cap;
  logic signed [AW-1:0] w_fb;
  logic signed [AW-1:0] w_acc;
  logic signed [AW-1:0] w_shr;
  logic signed [W-1:0]  w_est;
  logic signed [W-1:0]  w_dec;

  assign w_loc_ok = int'(bus.location) <= NUM_TAPS;
  assign w_wr     = bus.load_mem && w_loc_ok;
  // A coefficient write always takes priority over a coincident sample.
  assign w_accept = bus.signal_in_valid && !bus.load_mem && r_done;
  assign w_s0_cap = (bus.mem_data[15:4] != 12'd0) ? 4'd15 : bus.mem_data[3:0];

  always_comb begin
    w_fb = '0;
    if (bus.dfe_en) begin
      for (int k = 1; k <= NUM_TAPS; k++) begin
        w_fb = w_fb + (AW'(r_hist[k]) * AW'(r_coef[k]));
      end
    end
    w_acc = (AW'(bus.signal_in) <<< r_s0) - w_fb;
    w_shr = w_acc >>> r_s0;
    if (w_shr > SAT_MAX)      w_est = SAT_MAX[W-1:0];
    else if (w_shr < SAT_MIN) w_est = SAT_MIN[W-1:0];
    else                      w_est = w_shr[W-1:0];
    // Threshold ties resolve to the upper level.
    if (PAM_LEVELS == 2)        w_dec = (int'(w_est) >= 0) ? LV_P1 : LV_M1;
    else if (int'(w_est) >= S)  w_dec = LV_P3;
    else if (int'(w_est) >= 0)  w_dec = LV_P1;
    else if (int'(w_est) >= -S) w_dec = LV_M1;
    else                        w_dec = LV_M3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0      <= '0;
      r_loaded  <= '0;
      r_done    <= 1'b0;
      r_loc_err <= 1'b0;
      r_valid   <= 1'b0;
      r_out     <= '0;
      r_est     <= '0;
      r_drop    <= '0;
      for (int k = 1; k <= NUM_TAPS; k++) begin
        r_coef[k] <= '0;
        r_hist[k] <= '0;
      end
    end else begin
      r_loc_err <= bus.load_mem && !w_loc_ok;
      if (w_wr) begin
        if (bus.location == 8'd0) r_s0 <= w_s0_cap;
        for (int k = 1; k <= NUM_TAPS; k++) begin
          if (bus.location == 8'(k)) r_coef[k] <= bus.mem_data[31:16];
        end
        for (int k = 0; k <= NUM_TAPS; k++) begin
          if (bus.location == 8'(k)) r_loaded[k] <= 1'b1;
        end
      end
      // Sticky: later rewrites never drop done_wait.
      r_done  <= r_done | (&r_loaded);
      r_valid <= w_accept;
      if (w_accept) begin
        r_out     <= w_dec;
        r_est     <= w_est;
        r_hist[1] <= w_dec;
        for (int k = 2; k <= NUM_TAPS; k++) begin
          r_hist[k] <= r_hist[k-1];
        end
      end
      if (bus.signal_in_valid && !w_accept && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

  assign bus.done_wait        = r_done;
  assign bus.loc_err          = r_loc_err;
  assign bus.signal_out       = r_out;
  assign bus.signal_out_valid = r_valid;
  assign bus.est_out          = r_est;
  assign bus.drop_cnt         = r_drop;
endmodule

// File: tb/tb_dfe_multitap_pam.sv
// Bench for dfe_multitap_pam: directed and random stimulus, an arithmetic reference model
// that feeds an expected queue, and a negedge monitor that pops and compares every output strobe.
module tb_dfe_multitap_pam;
  localparam int NT = 4;
  localparam int W  = 8;
  localparam int S  = 56;
  localparam int PL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dfe_multitap_pam_if #(.SIGNAL_RESOLUTION(W)) bus ();

  dfe_multitap_pam #(
    .NUM_TAPS(NT), .SIGNAL_RESOLUTION(W), .SYMBOL_SEPERATION(S), .PAM_LEVELS(PL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q[$];

  // Reference model state
  int m_s0;
  int m_h[NT+1];
  bit m_loaded[NT+1];
  bit m_done;
  int m_hist[$];
  int m_drop;
  bit m_loc_err;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_s0 = 0;
    for (int k = 0; k <= NT; k++) begin
      m_h[k] = 0;
      m_loaded[k] = 1'b0;
    end
    m_done = 1'b0;
    m_hist = {};
    for (int k = 0; k < NT; k++) m_hist.push_back(0);
    m_drop = 0;
    m_loc_err = 1'b0;
  endtask

  function automatic int iabs(input longint v);
    return (v < 0) ? int'(-v) : int'(v);
  endfunction

  // Equalize one sample arithmetically, pick the nearest level, and record the decision.
  task automatic ref_sample(input int x, input bit en);
    longint acc, div, est;
    int lv[$];
    int best;
    div = longint'(1) << m_s0;
    acc = longint'(x) * div;
    if (en) for (int k = 1; k <= NT; k++) acc -= longint'(m_hist[k-1]) * longint'(m_h[k]);
    est = acc / div;
    if ((acc % div != 0) && (acc < 0)) est -= 1;
    if (est > 127) est = 127;
    if (est < -128) est = -128;
    if (PL == 4) lv = '{-(3*S/2), -(S/2), S/2, 3*S/2};
    else         lv = '{-(S/2), S/2};
    best = lv[0];
    foreach (lv[i]) if (iabs(est - lv[i]) <= iabs(est - best)) best = lv[i];
    exp_q.push_back({W'(best), W'(est)});
    m_hist.push_front(best);
    void'(m_hist.pop_back());
  endtask

  // Advance one clock, applying the current inputs to the model exactly as the edge sees them.
  task automatic step();
    bit all_ld;
    bit acc;
    @(posedge clk);
    all_ld = 1'b1;
    for (int k = 0; k <= NT; k++) if (!m_loaded[k]) all_ld = 1'b0;
    acc = bus.signal_in_valid && !bus.load_mem && m_done;
    if (acc) ref_sample(int'(bus.signal_in), bus.dfe_en);
    else if (bus.signal_in_valid && m_drop < 65535) m_drop++;
    m_loc_err = bus.load_mem && (int'(bus.location) > NT);
    if (bus.load_mem && int'(bus.location) <= NT) begin
      if (bus.location == 8'd0) m_s0 = (bus.mem_data[15:0] > 16'd15) ? 15 : int'(bus.mem_data[15:0]);
      else m_h[bus.location] = int'($signed(bus.mem_data[31:16]));
      m_loaded[bus.location] = 1'b1;
    end
    m_done = m_done || all_ld;
    #1;
  endtask

  task automatic idle_in();
    bus.signal_in_valid = 1'b0;
    bus.signal_in = '0;
    bus.load_mem = 1'b0;
    bus.location = '0;
    bus.mem_data = '0;
  endtask

  task automatic load(input int loc, input int mant, input int sh);
    bus.load_mem = 1'b1;
    bus.location = 8'(loc);
    bus.mem_data = {16'(mant), 16'(sh)};
    step();
    bus.load_mem = 1'b0;
  endtask

  task automatic sample(input int x);
    bus.signal_in_valid = 1'b1;
    bus.signal_in = W'(x);
    step();
    bus.signal_in_valid = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_drop_cnt"}, int'(bus.drop_cnt), m_drop);
    check({tag, "_done_wait"}, int'(bus.done_wait), int'(m_done));
    check({tag, "_loc_err"}, int'(bus.loc_err), int'(m_loc_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_signal_out"}, int'(bus.signal_out), 0);
    check({tag, "_est_out"}, int'(bus.est_out), 0);
    check({tag, "_valid"}, int'(bus.signal_out_valid), 0);
    check({tag, "_done_wait"}, int'(bus.done_wait), 0);
    check({tag, "_drop_cnt"}, int'(bus.drop_cnt), 0);
    check({tag, "_loc_err"}, int'(bus.loc_err), 0);
  endtask

  // Monitor: every output strobe must match the oldest expected result.
  initial begin
    logic [2*W-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.signal_out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got signal_out_valid=1 signal_out=%0d, expected no output",
                   bus.signal_out);
        end else begin
          e = exp_q.pop_front();
          check("signal_out", int'(bus.signal_out), int'($signed(e[2*W-1:W])));
          check("est_out", int'(bus.est_out), int'($signed(e[W-1:0])));
        end
      end
    end
  end

  initial begin
    int pat[4] = '{30, 56, -57, 0};
    idle_in();
    bus.dfe_en = 1'b1;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Samples before any coefficient load are all dropped.
    repeat (3) sample(int'($urandom_range(0, 255)) - 128);
    check_status("preload");

    // Zero taps; done_wait rises one cycle after the final load.
    load(0, 0, 0);
    for (int k = 1; k <= NT; k++) load(k, 0, 0);
    check_status("last_load");
    step();
    check_status("load_done");
    foreach (pat[i]) sample(pat[i]);
    step();

    // Single tap, then same response with s0=2 and h1=4.
    load(1, 1, 0);
    sample(84);
    sample(112);
    load(0, 0, 2);
    load(1, 4, 0);
    sample(84);
    sample(112);

    // Saturation: previous decision -84 via bypass, then h1=-16.
    load(0, 0, 0);
    load(1, -16, 0);
    bus.dfe_en = 1'b0;
    sample(-100);
    bus.dfe_en = 1'b1;
    sample(127);
    check("sat_est_out", int'(bus.est_out), -128);
    check("sat_signal_out", int'(bus.signal_out), -84);

    // Out-of-range write: one-cycle loc_err, done_wait untouched.
    load(7, 5, 5);
    check_status("bad_write");
    step();
    check_status("bad_write_after");

    // Feedback bypass with h1=1.
    load(1, 1, 0);
    bus.dfe_en = 1'b0;
    sample(84);
    sample(112);
    bus.dfe_en = 1'b1;

    // Load and sample in the same cycle: load wins, sample is dropped.
    bus.load_mem = 1'b1;
    bus.location = 8'd1;
    bus.mem_data = {16'sd2, 16'd0};
    bus.signal_in_valid = 1'b1;
    bus.signal_in = W'(50);
    step();
    idle_in();
    check_status("collision");
    sample(90);

    // Random traffic including rewrites, shift capping, bad locations and bypass.
    for (int i = 0; i < 300; i++) begin
      bus.signal_in_valid = ($urandom_range(0, 3) != 0);
      bus.signal_in = W'($urandom_range(0, 255));
      bus.load_mem = ($urandom_range(0, 9) == 0);
      bus.location = 8'($urandom_range(0, 6));
      bus.mem_data = {16'($urandom_range(0, 40) - 20), 16'($urandom_range(0, 20))};
      bus.dfe_en = ($urandom_range(0, 7) != 0);
      step();
      check_status("random");
    end
    idle_in();
    bus.dfe_en = 1'b1;
    step();

    // Reset while a result is being presented.
    sample(40);
    #1 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    exp_q.delete();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) sample(60);
    check_status("post_reset");
    step();
    step();
    check("exp_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
